psum_deskew_fifo: RTL and testbench
===================================

# psum_deskew_fifo

Output-side collector for the MAC array. It captures the array's south-edge partial sums, which arrive column-skewed with one `valid` bit per column, into per-column circular buffers. It then presents column-aligned rows to the downstream accumulator or SRAM writer through a pop handshake. It sits directly below the array, taking `out_s`/`valid` as its inputs.

## Interface
- `bw`, default 4: activation/weight width. Carried for consistency; unused internally.
- `psum_bw`, default 16: partial-sum width per column.
- `col`, default 8: number of columns / independent buffers.
- `depth`, default 16: entries per column buffer. Must be a power of two, ≥2.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `in_s` input, psum_bw*col bits: array south outputs. Column c is at [psum_bw*(c+1)-1 : psum_bw*c].
- `valid_in` input, col bits: per-column write strobe; bit c qualifies column c of `in_s`.
- `rd` input, 1 bit: pop request for one aligned row.
- `out` output, psum_bw*col bits: head entry of every column buffer, same bit mapping as `in_s`.
- `o_valid` output, 1 bit: every column buffer is non-empty.
- `o_full` output, 1 bit: at least one column buffer holds `depth` entries.
- `o_ready` output, 1 bit: equals `!o_full`.
- `overflow` output, 1 bit: sticky; a write was dropped.
- `underflow` output, 1 bit: sticky; `rd` was asserted while `o_valid` was 0.

## Operation
- Storage: `col` independent RAM arrays, each `depth` × `psum_bw`.
- Pointers: one write pointer per column, each log2(depth)+1 bits. There is a single shared read pointer of the same width, because pops are always row-wide.
- `count[c]` = `wptr[c] - rptr`, computed modulo 2^(log2(depth)+1). Values range from 0 to `depth`.
- Write accept for column c: `valid_in[c] && (count[c] < depth || pop)`.
  - Accepted write: store `in_s` column c at `wptr[c]` modulo `depth`, then increment `wptr[c]`.
  - Column writes are independent of each other; any subset of columns may write in a cycle.
- `pop` = `rd && o_valid`. On pop, `rptr` increments.
- `o_valid` = AND over c of (`count[c]` != 0).
  - Counts are evaluated before the current cycle's writes.
  - A column that is empty and being written in the same cycle does not count as non-empty.
- `out` is first-word-fall-through: column c shows `mem[c][rptr mod depth]`. `out` content is don't-care while `o_valid` = 0.
- `o_full` = OR over c of (`count[c]` == `depth`). It is evaluated from registered counts.
- Full column with write and no pop in the same cycle:
  - The write is dropped and `overflow` is set.
  - The other columns' writes in that cycle still proceed.
- Full column with write and pop in the same cycle: the write is accepted, `count` is unchanged, and there is no overflow.
- `rd` with `o_valid` = 0: no pointer change, and `underflow` is set.
- Wrap-around: pointers wrap naturally. The extra MSB distinguishes full from empty.
- `overflow` and `underflow` clear only on `reset`.

## Timing
- Reset (asynchronous, immediate):
  - All pointers go to 0.
  - `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `overflow` = 0, `underflow` = 0.
  - `out` is don't-care.
  - Memory contents are not cleared.
- Reset asserted mid-operation: all buffered data is discarded immediately, and outputs take their reset values within the same cycle.
- Write-to-read latency: a write at rising edge N makes its data visible on `out` after edge N. `o_valid` rises after edge N if this write completes the row.
- Pop at edge N: `out` shows the next row after edge N. `o_valid` drops after edge N if any column becomes empty.
- Flags: `o_full`, `o_ready` and the sticky flags update on the edge that causes the condition. All outputs are registered-state derived, with no combinational path from `valid_in` or `rd`.
- Skew tolerance: column c may lead column 0 by up to `depth` entries without loss.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `overflow` = 0 and `underflow` = 0 before the next edge.
- Skewed row: on cycle c (c = 0..7), pulse `valid_in[c]` with column c = 16'h0100+c -> `o_valid` stays 0 through cycle 6 and goes to 1 after the cycle-7 edge. `out` = {16'h0107, …, 16'h0100}. One `rd` -> `o_valid` = 0.
- Fill and overflow: write rows 0..15 with value = row index on all columns -> `o_full` = 1. A 17th row write -> dropped and `overflow` = 1. Then 16 pops -> `out` sequence 0..15 in order, then `o_valid` = 0.
- Full with simultaneous pop: at full, write row 16 and assert `rd` -> `overflow` stays 0 and `count` stays 16. Subsequent pops return 1..16.
- Underflow: `rd` = 1 while empty -> pointers unchanged, `underflow` = 1. It stays 1 after later valid traffic.
- Wrap: stream 40 rows with pops interleaved so occupancy stays at 3 -> all 40 values are returned in order, with no flags set.

Source files
------------

// File: rtl/psum_deskew_fifo.sv
// Per-column deskew buffers below the MAC array: skewed column writes in,
// column-aligned rows out through a pop handshake with FWFT data.
module psum_deskew_fifo #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in_s,
    input  logic [col-1:0]         valid_in,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow,
    output logic                   underflow
);

    // bw only rides along for interface parity with the array
    localparam int AW = $clog2(depth) + 0 * bw;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(depth);

    logic [psum_bw-1:0] mem_q [col][depth];

    logic [PW-1:0] wptr_q [col];
    logic [PW-1:0] wptr_d [col];
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          udf_q;
    logic          udf_d;

    logic [PW-1:0]  cnt [col];
    logic [col-1:0] nonempty;
    logic [col-1:0] full_c;
    logic [col-1:0] wr_en;
    logic [col-1:0] drop;
    logic           pop;

    // occupancy is taken from registered pointers only
    always_comb begin
        for (int c = 0; c < col; c++) begin
            cnt[c]      = wptr_q[c] - rptr_q;
            nonempty[c] = (cnt[c] != '0);
            full_c[c]   = (cnt[c] == DEPTH_P);
        end
    end

    assign o_valid = &nonempty;
    assign o_full  = |full_c;
    assign o_ready = !o_full;
    assign pop     = rd && o_valid;

    // a full column still accepts when the same edge frees a slot
    always_comb begin
        for (int c = 0; c < col; c++) begin
            wr_en[c]  = valid_in[c] && (!full_c[c] || pop);
            drop[c]   = valid_in[c] && full_c[c] && !pop;
            wptr_d[c] = wptr_q[c] + PW'(wr_en[c]);
        end
    end

    always_comb begin
        rptr_d = rptr_q + PW'(pop);
        ovf_d  = ovf_q | (|drop);
        udf_d  = udf_q | (rd && !o_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= '0;
            end
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                wptr_q[c] <= wptr_d[c];
            end
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // storage is never cleared; pointers alone define contents
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_en[c]) begin
                mem_q[c][wptr_q[c][AW-1:0]] <= in_s[c*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        out = '0;
        for (int c = 0; c < col; c++) begin
            out[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[AW-1:0]];
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_psum_deskew_fifo.sv
// Directed bench for psum_deskew_fifo: queued expected rows are checked
// by a monitor on every accepted pop; flags are checked inline.
module tb_psum_deskew_fifo;

    localparam int PB = 16;
    localparam int C  = 8;
    localparam int D  = 16;
    localparam int W  = PB * C;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_s;
    logic [C-1:0] valid_in;
    logic         rd;
    logic [W-1:0] out;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic         overflow;
    logic         underflow;

    int checks;
    int errors;
    int pops_seen;
    logic [W-1:0] exp_q [$];

    psum_deskew_fifo #(
        .bw(4), .psum_bw(PB), .col(C), .depth(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_s     (in_s),
        .valid_in (valid_in),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor: the head row is compared on every accepted pop
    always @(negedge clk) begin
        if (reset === 1'b0 && rd === 1'b1 && o_valid === 1'b1) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %h want no pop", out);
            end else begin
                chk("pop_row", out, exp_q.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] row_all(input logic [PB-1:0] v);
        logic [W-1:0] r;
        for (int c = 0; c < C; c++) r[c*PB +: PB] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] row_idx(input int i);
        logic [W-1:0] r;
        for (int c = 0; c < C; c++) r[c*PB +: PB] = {8'(i), 8'(c)};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input logic v, input logic f,
                             input logic ov, input logic un);
        chk({nm, "_valid"}, W'(o_valid), W'(v));
        chk({nm, "_full"}, W'(o_full), W'(f));
        chk({nm, "_ready"}, W'(o_ready), W'(!f));
        chk({nm, "_ovf"}, W'(overflow), W'(ov));
        chk({nm, "_udf"}, W'(underflow), W'(un));
    endtask

    task automatic mid_reset(input string nm);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_flags(nm, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        cyc();
        reset = 1'b0;
    endtask

    task automatic write_row(input logic [W-1:0] r, input logic do_rd);
        in_s     = r;
        valid_in = '1;
        rd       = do_rd;
        cyc();
        valid_in = '0;
        rd       = 1'b0;
    endtask

    task automatic drain(input int n);
        rd = 1'b1;
        repeat (n) cyc();
        rd = 1'b0;
    endtask

    initial begin
        logic [W-1:0] skew_row;
        checks    = 0;
        errors    = 0;
        pops_seen = 0;
        in_s      = '0;
        valid_in  = '0;
        rd        = 1'b0;
        reset     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_flags("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        cyc();

        // skewed row: column c arrives on cycle c, other lanes hold junk
        for (int c = 0; c < C; c++) skew_row[c*PB +: PB] = 16'h0100 + 16'(c);
        exp_q.push_back(skew_row);
        for (int c = 0; c < C; c++) begin
            in_s = row_all(16'hDEAD);
            in_s[c*PB +: PB] = 16'h0100 + 16'(c);
            valid_in = C'(1) << c;
            cyc();
            chk($sformatf("skew_valid_c%0d", c), W'(o_valid), W'(c == C - 1));
        end
        valid_in = '0;
        chk("skew_out", out, skew_row);
        drain(1);
        chk("skew_after_pop", W'(o_valid), W'(0));

        // fill to depth, then one dropped row
        for (int r = 0; r < D; r++) begin
            exp_q.push_back(row_all(16'(r)));
            write_row(row_all(16'(r)), 1'b0);
        end
        chk_flags("fill", 1'b1, 1'b1, 1'b0, 1'b0);
        write_row(row_all(16'h0BAD), 1'b0);
        chk_flags("ovf", 1'b1, 1'b1, 1'b1, 1'b0);
        drain(D);
        chk_flags("fill_drained", 1'b0, 1'b0, 1'b1, 1'b0);

        // buffered data must vanish on a mid-cycle reset
        write_row(row_all(16'h7777), 1'b0);
        chk("pre_reset_valid", W'(o_valid), W'(1));
        mid_reset("rst_mid");

        // full with simultaneous pop: write accepted, count stays at depth
        for (int r = 0; r < D; r++) begin
            exp_q.push_back(row_all(16'(r)));
            write_row(row_all(16'(r)), 1'b0);
        end
        exp_q.push_back(row_all(16'(D)));
        write_row(row_all(16'(D)), 1'b1);
        chk_flags("full_pop", 1'b1, 1'b1, 1'b0, 1'b0);
        drain(D);
        chk_flags("full_pop_drained", 1'b0, 1'b0, 1'b0, 1'b0);

        // underflow is sticky across later traffic
        drain(1);
        chk_flags("udf", 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(row_all(16'h0055));
        write_row(row_all(16'h0055), 1'b0);
        chk("udf_row_valid", W'(o_valid), W'(1));
        drain(1);
        chk_flags("udf_sticky", 1'b0, 1'b0, 1'b0, 1'b1);
        mid_reset("rst_udf");

        // wrap: 40 rows at steady occupancy 3
        pops_seen = 0;
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(row_idx(i));
            write_row(row_idx(i), i >= 3);
        end
        drain(3);
        chk_flags("wrap", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pop_count", W'(pops_seen), W'(40));
        chk("sb_empty", W'(exp_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
